// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch -- instruction fetch stage with a 2-entry prefetch FIFO.
//
// Issues single-outstanding word reads to instruction memory, queues returned
// {PC, inst} pairs and presents the head entry to decode. Branch and jump
// redirects flush the queue; an in-flight read at redirect time is drained
// and discarded before the target is fetched.
//
// Optional feature: define IF_STALL_CNT_EN to add o_IF_stallCnt, a wrapping
// count of cycles where a valid instruction is held by i_IF_pause.
//
// Ports
//   clk, rstn         clock, synchronous active-low reset
//   o_IF_imemReq      memory read request (held until i_IF_imemAck)
//   o_IF_imemAddr     request word address
//   i_IF_imemAck      request accepted, i_IF_imemRData valid
//   i_IF_imemRData    returned instruction word
//   i_IF_pause        decode stall; head entry is kept
//   i_IF_brTaken      branch redirect to i_IF_brTarget (highest priority)
//   i_IF_brTarget     branch target
//   i_IF_jump         J-type redirect using i_IF_jumpLowPC
//   i_IF_jumpLowPC    J-type 26-bit target field
//   o_IF_valid        head entry present
//   o_IF_PC           head PC (0 when empty)
//   o_IF_inst         head instruction (0 when empty)
//   o_IF_stallCnt     stall cycle counter (IF_STALL_CNT_EN only)
// -----------------------------------------------------------------------------

package instr_fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    ST_REQ     = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

endpackage

module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        o_IF_imemReq,
  output logic [31:0] o_IF_imemAddr,
  input  logic        i_IF_imemAck,
  input  logic [31:0] i_IF_imemRData,
  input  logic        i_IF_pause,
  input  logic        i_IF_brTaken,
  input  logic [31:0] i_IF_brTarget,
  input  logic        i_IF_jump,
  input  logic [25:0] i_IF_jumpLowPC,
  output logic        o_IF_valid,
  output logic [31:0] o_IF_PC,
  output logic [31:0] o_IF_inst
`ifdef IF_STALL_CNT_EN
  ,
  output logic [31:0] o_IF_stallCnt
`endif
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OCC_W = 2;

  // State registers
  fetch_state_e      r_state;
  logic              r_req;
  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_pc;
  fetch_entry_t      r_head;
  fetch_entry_t      r_tail;
  logic [OCC_W-1:0]  r_occ;
  logic              r_valid;

  // Next-state values
  fetch_state_e      w_state_n;
  logic              w_req_n;
  logic [XLEN-1:0]   w_addr_n;
  logic [XLEN-1:0]   w_pc_n;
  fetch_entry_t      w_head_n;
  fetch_entry_t      w_tail_n;
  logic [OCC_W-1:0]  w_occ_n;

  logic              w_ack;
  logic              w_redirect;
  logic              w_enq;
  logic              w_deq;
  logic [3:0]        w_jmp_hi;
  logic [XLEN-1:0]   w_target;
  fetch_entry_t      w_new;

  // Redirect target; jump region is taken from the presented PC plus 4
  always_comb begin
    w_ack      = r_req & i_IF_imemAck;
    w_redirect = i_IF_brTaken | i_IF_jump;
    w_jmp_hi   = r_head.pc[31:28] + 4'(&r_head.pc[27:2]);
    w_target   = i_IF_brTaken ? i_IF_brTarget : {w_jmp_hi, i_IF_jumpLowPC, 2'b00};
    // Data returned while discarding belongs to the pre-redirect stream
    w_enq      = w_ack & (r_state == ST_REQ) & ~w_redirect;
    w_deq      = r_valid & ~i_IF_pause & ~w_redirect;
    w_new      = '{pc: r_addr, inst: i_IF_imemRData};
  end

  // Two-entry shift FIFO; head is kept zero when empty so it drives outputs directly
  always_comb begin
    w_head_n = r_head;
    w_tail_n = r_tail;
    w_occ_n  = r_occ;
    if (w_redirect) begin
      w_head_n = '0;
      w_occ_n  = '0;
    end else begin
      case ({w_enq, w_deq})
        2'b11: begin
          if (r_occ == OCC_W'(2)) begin
            w_head_n = r_tail;
            w_tail_n = w_new;
          end else begin
            w_head_n = w_new;
          end
        end
        2'b01: begin
          w_head_n = (r_occ == OCC_W'(2)) ? r_tail : '0;
          w_occ_n  = r_occ - OCC_W'(1);
        end
        2'b10: begin
          if (r_occ == OCC_W'(0)) w_head_n = w_new;
          else                    w_tail_n = w_new;
          w_occ_n = r_occ + OCC_W'(1);
        end
        default: ;
      endcase
    end
    w_pc_n = w_redirect ? w_target : (w_enq ? r_pc + XLEN'(4) : r_pc);
  end

  // Next-state and request logic
  always_comb begin
    w_state_n = r_state;
    w_req_n   = r_req;
    w_addr_n  = r_addr;
    if (r_req && !i_IF_imemAck) begin
      // Request still in flight: address must stay put until ack
      if (w_redirect || (r_state == ST_DISCARD)) w_state_n = ST_DISCARD;
    end else if (w_occ_n < OCC_W'(2)) begin
      w_state_n = ST_REQ;
      w_req_n   = 1'b1;
      w_addr_n  = w_pc_n;
    end else begin
      w_state_n = ST_HOLD;
      w_req_n   = 1'b0;
      w_addr_n  = w_pc_n;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_REQ;
      r_req   <= 1'b0;
      r_addr  <= RESET_PC;
      r_pc    <= RESET_PC;
      r_head  <= '0;
      r_tail  <= '0;
      r_occ   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_req   <= w_req_n;
      r_addr  <= w_addr_n;
      r_pc    <= w_pc_n;
      r_head  <= w_head_n;
      r_tail  <= w_tail_n;
      r_occ   <= w_occ_n;
      r_valid <= (w_occ_n != OCC_W'(0));
    end
  end

  assign o_IF_imemReq  = r_req;
  assign o_IF_imemAddr = r_addr;
  assign o_IF_valid    = r_valid;
  assign o_IF_PC       = r_head.pc;
  assign o_IF_inst     = r_head.inst;

`ifdef IF_STALL_CNT_EN
  logic [XLEN-1:0] r_stall_cnt;

  // Counts cycles where decode holds a valid instruction
  always_ff @(posedge clk) begin
    if (!rstn)                      r_stall_cnt <= '0;
    else if (r_valid && i_IF_pause) r_stall_cnt <= r_stall_cnt + XLEN'(1);
  end

  assign o_IF_stallCnt = r_stall_cnt;
`endif

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rstn  in  1  reset; synchronous, active-low.
REQ-004 o_IF_imemReq  out  1  instruction-memory read request.
REQ-005 o_IF_imemAddr  out  32  word address of the request.
REQ-006 i_IF_imemAck  in  1  request accepted and data returned this cycle.
REQ-007 i_IF_imemRData  in  32  instruction word, valid when ack=1.
REQ-008 i_IF_pause  in  1  decode-stage stall; head entry is not consumed.
REQ-009 i_IF_brTaken  in  1  branch redirect from decode.
REQ-010 i_IF_brTarget  in  32  branch target address.
REQ-011 i_IF_jump  in  1  J-type redirect from decode.
REQ-012 i_IF_jumpLowPC  in  26  J-type target field.
REQ-013 o_IF_valid  out  1  o_IF_PC/o_IF_inst hold a fetched instruction.
REQ-014 o_IF_PC  out  32  address of the presented instruction.
REQ-015 o_IF_inst  out  32  presented instruction word.

Function
REQ-016 The block SHALL hold a fetch PC, a 2-entry FIFO of {PC, inst} and an FSM with states REQ, HOLD and DISCARD.
REQ-017 At most one request SHALL be outstanding; req, once high, SHALL stay high with a stable address until ack.
REQ-018 A new request SHALL be issued only when FIFO occupancy plus outstanding requests is below 2 (state REQ); otherwise the FSM SHALL be in HOLD with req=0.
REQ-019 On ack in REQ, {addr, rdata} SHALL be enqueued and fetch PC SHALL advance by 4, wrapping 32'hFFFF_FFFC to 32'h0000_0000.
REQ-020 With zero-wait ack, sustained throughput SHALL be one instruction per cycle while i_IF_pause=0.
REQ-021 o_IF_valid SHALL be 1 exactly when the FIFO is non-empty; o_IF_PC/o_IF_inst SHALL show the head entry, or 32'h0 for both when empty.
REQ-022 The head SHALL be dequeued on a cycle with o_IF_valid=1 and i_IF_pause=0; enqueue and dequeue in the same cycle SHALL keep occupancy unchanged.
REQ-023 The redirect target SHALL be i_IF_brTarget when i_IF_brTaken=1, else {o_IF_PC+4 [31:28], i_IF_jumpLowPC, 2'b00} when i_IF_jump=1; brTaken has priority.
REQ-024 On a redirect, the FIFO SHALL be flushed and fetch PC SHALL load the target at the next edge; redirect overrides pause and any same-cycle enqueue.
REQ-025 If a request is outstanding and not acked in the redirect cycle, the FSM SHALL enter DISCARD, keep req high with the old address and drop the data on its ack, then request the target.
REQ-026 A redirect while in DISCARD SHALL update the target and remain in DISCARD.

Reset
REQ-027 While rstn=0 at an edge: FIFO empty, FSM in REQ, fetch PC=RESET_PC, o_IF_valid=0, o_IF_PC=0, o_IF_inst=0, o_IF_imemReq=0, o_IF_imemAddr=RESET_PC.
REQ-028 req SHALL first assert the cycle after rstn goes high; reset asserted mid-request SHALL abandon the request without waiting for ack.

Configuration
REQ-029 With macro IF_STALL_CNT_EN defined, output o_IF_stallCnt [31:0] SHALL exist: reset to 0 and incremented (wrapping) each cycle with o_IF_valid=1 and i_IF_pause=1.
REQ-030 With IF_STALL_CNT_EN undefined, o_IF_stallCnt and its counter SHALL be absent and all other behaviour identical.

Verification
REQ-031 Reset release, ack tied high -> addrs 0,4,8,... on consecutive cycles; o_IF_valid=1 from cycle 2 with PC 0,4,8.
REQ-032 pause held 3 cycles with FIFO filling -> req drops after occupancy 2, head stays PC=0x8 and resumes in order (0x8, 0xC).
REQ-033 brTaken with target 0x100 while a request to 0x10 waits 2 cycles for ack -> 0x10 data dropped, next request to 0x100, valid=0 until it returns.
REQ-034 jump with lowPC 26'h0000040 and o_IF_PC=0x1000_0000 -> next fetch 0x1000_0100; simultaneous brTaken to 0x200 -> fetch 0x200.
REQ-035 RESET_PC=32'hFFFF_FFFC -> fetch 0xFFFF_FFFC then 0x0000_0000.
REQ-036 With IF_STALL_CNT_EN: 5 cycles valid and paused, 2 cycles paused with FIFO empty -> o_IF_stallCnt=5.
